// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
//  arb_state_e : arbiter FSM states
//  rr_pick     : rotating first-set search over a request vector
package arb_pkg;

    typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e;

    // Widest request vector rr_pick accepts; callers zero-extend to this.
    localparam int unsigned RR_MAX = 64;

    // Returns the first set bit of req scanning last+1 .. last+n (mod n).
    // n must be a power of two. Returns last when no bit is set.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned        last,
                                            input int unsigned        n);
        logic       found;
        logic [5:0] idx;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = 6'((last + k) & (n - 1));
            if (!found && (k <= n) && req[idx]) begin
                rr_pick = 32'(idx);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decoder.sv
// Binary-to-one-hot decoder.
//  idx    : binary index, ENCODE_WIDTH bits
//  onehot : exactly one bit set at position idx
module decoder
    import arb_pkg::*;
#(
    parameter int ENCODE_WIDTH = 2
) (
    input  logic [ENCODE_WIDTH-1:0]    idx,
    output logic [2**ENCODE_WIDTH-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one resource among 2**ENCODE_WIDTH requesters.
// A grant is held until the owner releases, drops its request, or reaches
// MAX_HOLD consecutive cycles; one idle turnaround cycle follows every grant.
//  clk         : rising-edge clock
//  rst         : synchronous active-high reset
//  req         : level request per requester
//  release_gnt : owner ends its grant this cycle (ignored when idle)
//  gnt         : one-hot grant, zero when gnt_valid=0
//  gnt_idx     : index of current/last owner
//  gnt_valid   : a grant is active
//  timeout     : one-cycle pulse after a grant revoked by the hold limit
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int ENCODE_WIDTH = 2,
    parameter int REQ_WIDTH    = 2**ENCODE_WIDTH,
    parameter int MAX_HOLD     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQ_WIDTH-1:0]    req,
    input  logic                    release_gnt,
    output logic [REQ_WIDTH-1:0]    gnt,
    output logic [ENCODE_WIDTH-1:0] gnt_idx,
    output logic                    gnt_valid,
    output logic                    timeout
);

    // Keep the counter at least one bit wide when the limit is disabled.
    localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_e              state;
    logic [ENCODE_WIDTH-1:0] last;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [ENCODE_WIDTH-1:0] next_idx;
    logic [REQ_WIDTH-1:0]    dec_onehot;
    logic                    at_limit;
    logic                    owner_req;

    assign next_idx  = ENCODE_WIDTH'(rr_pick(RR_MAX'(req), 32'(last), 32'(REQ_WIDTH)));
    assign owner_req = req[gnt_idx];
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(HOLD_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= ENCODE_WIDTH'(REQ_WIDTH - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        gnt_idx   <= next_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_gnt || !owner_req || at_limit) begin
                        last      <= gnt_idx;
                        gnt_valid <= 1'b0;
                        state     <= ST_IDLE;
                        // Release or drop on the limit edge is a normal end.
                        timeout   <= at_limit && !release_gnt && owner_req;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    decoder #(.ENCODE_WIDTH(ENCODE_WIDTH)) u_dec (
        .idx    (gnt_idx),
        .onehot (dec_onehot)
    );

    assign gnt = dec_onehot & {REQ_WIDTH{gnt_valid}};

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0;
    logic       rel = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_grant_arbiter #(.ENCODE_WIDTH(2), .MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_gnt (rel),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout     (timeout)
    );

    task automatic apply_reset();
        rst = 1'b1; req = 4'b0; rel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; req = 4'b1111; rel = 1'b0;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back('{gnt: 4'b0000, tmo: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== 1'b0 || timeout !== e.tmo || gnt_idx !== 2'd0) begin
                n_bad++;
                $display("FAIL reset[%0d]: gnt=%b vld=%b tmo=%b idx=%0d, want gnt=%b vld=0 tmo=%b idx=0",
                         c, gnt, gnt_valid, timeout, gnt_idx, e.gnt, e.tmo);
            end
        end
        rst = 1'b0;
        exp_q.push_back('{gnt: 4'b0001, tmo: 1'b0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== e.gnt || gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_first_grant: gnt=%b vld=%b idx=%0d, want gnt=%b vld=1 idx=0",
                     gnt, gnt_valid, gnt_idx, e.gnt);
        end
    endtask

    // All requesting, owner releases every cycle: strict rotation with gaps.
    task automatic test_rotate();
        logic [3:0] x_gnt [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            req = 4'b1111; rel = 1'b1;
            exp_q.push_back('{gnt: x_gnt[i], tmo: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL rotate[%0d]: gnt=%b vld=%b tmo=%b, want gnt=%b vld=%b tmo=%b",
                         i, gnt, gnt_valid, timeout, e.gnt, |e.gnt, e.tmo);
            end
        end
        rel = 1'b0;
    endtask

    // Sole requester holds: revoked after 8 cycles, timeout pulse, re-granted.
    task automatic test_hold_limit();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            req = 4'b0100; rel = 1'b0;
            exp_q.push_back('{gnt: (i == 8) ? 4'b0000 : 4'b0100, tmo: (i == 8)});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL hold_limit[%0d]: gnt=%b vld=%b tmo=%b, want gnt=%b vld=%b tmo=%b",
                         i, gnt, gnt_valid, timeout, e.gnt, |e.gnt, e.tmo);
            end
        end
    endtask

    // Release coincides with the limit edge: no timeout.
    task automatic test_release_at_limit();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            req = 4'b0100; rel = (i == 8);
            exp_q.push_back('{gnt: (i == 8) ? 4'b0000 : 4'b0100, tmo: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL release_at_limit[%0d]: gnt=%b vld=%b tmo=%b, want gnt=%b vld=%b tmo=%b",
                         i, gnt, gnt_valid, timeout, e.gnt, |e.gnt, e.tmo);
            end
        end
        rel = 1'b0;
    endtask

    // Owner 1 drops its request; next scan starts at 2 and wraps to 0.
    task automatic test_owner_drop();
        logic [3:0] s_req [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0011};
        logic       s_rel [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] x_gnt [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            req = s_req[i]; rel = s_rel[i];
            exp_q.push_back('{gnt: x_gnt[i], tmo: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL owner_drop[%0d]: gnt=%b vld=%b tmo=%b, want gnt=%b vld=%b tmo=%b",
                         i, gnt, gnt_valid, timeout, e.gnt, |e.gnt, e.tmo);
            end
        end
    endtask

    // Other requesters cannot preempt; after the owner times out, rotation moves on.
    task automatic test_no_preempt();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            req = (i == 0) ? 4'b0001 : 4'b1111; rel = 1'b0;
            exp_q.push_back('{gnt: (i < 8) ? 4'b0001 : ((i == 8) ? 4'b0000 : 4'b0010),
                              tmo: (i == 8)});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL no_preempt[%0d]: gnt=%b vld=%b tmo=%b, want gnt=%b vld=%b tmo=%b",
                         i, gnt, gnt_valid, timeout, e.gnt, |e.gnt, e.tmo);
            end
        end
    endtask

    // Reset in the 3rd grant cycle of requester 2 clears rotation history.
    task automatic test_reset_mid_grant();
        logic [3:0] s_req [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b1111};
        logic       s_rst [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] x_gnt [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
        logic [1:0] x_idx [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            req = s_req[i]; rst = s_rst[i]; rel = 1'b0;
            exp_q.push_back('{gnt: x_gnt[i], tmo: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_valid !== (|e.gnt) || timeout !== e.tmo || gnt_idx !== x_idx[i]) begin
                n_bad++;
                $display("FAIL reset_mid_grant[%0d]: gnt=%b vld=%b tmo=%b idx=%0d, want gnt=%b vld=%b tmo=%b idx=%0d",
                         i, gnt, gnt_valid, timeout, gnt_idx, e.gnt, |e.gnt, e.tmo, x_idx[i]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_hold_limit();
        test_release_at_limit();
        test_owner_drop();
        test_no_preempt();
        test_reset_mid_grant();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
